// File: rtl/cordic_feeder.sv
// cordic_feeder: front-end of the rotation-mode CORDIC pipeline.
// Folds each requested angle into [-pi/2, pi/2), drives the initial x/y/z/v
// vector into stage 0, and gates admission with a credit counter because the
// downstream stage pipeline cannot stall. A quadrant-flip tag is delayed by
// STAGES cycles so it lines up with the last stage's valid.
//
// Optional feature: define CORDIC_FEEDER_STATS_EN to add accept/stall counters.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   angle request handshake (req_ready from credits only)
//   req_angle             signed angle, +/-pi == +/-2^(BITS-1)
//   credit_ret            pulse: downstream freed one result slot
//   x_out/y_out/z_out     initial vector to stage 0
//   v_out                 valid to stage 0
//   flip_tap              quadrant-flip flag aligned with the last stage's valid
//   credit_err            sticky credit-overflow flag
//   stat_accepts/stalls   (CORDIC_FEEDER_STATS_EN only) 32-bit wrapping counters
module cordic_feeder #(
  parameter int unsigned BITS    = 16,
  parameter int unsigned STAGES  = 16,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned XINIT   = 9949
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic signed [BITS-1:0] req_angle,
  input  logic                   credit_ret,
  output logic signed [BITS-1:0] x_out,
  output logic signed [BITS-1:0] y_out,
  output logic signed [BITS-1:0] z_out,
  output logic                   v_out,
  output logic                   flip_tap,
  output logic                   credit_err
`ifdef CORDIC_FEEDER_STATS_EN
  ,
  output logic [31:0]            stat_accepts,
  output logic [31:0]            stat_stalls
`endif
);

  localparam int unsigned CW = $clog2(CREDITS + 1);

  typedef struct packed {
    logic v;
    logic flip;
  } tag_t;

  logic signed [BITS-1:0] x_q, x_d;
  logic signed [BITS-1:0] y_q, y_d;
  logic signed [BITS-1:0] z_q, z_d;
  logic                   v_q, v_d;
  logic                   flip_q, flip_d;
  tag_t [STAGES-1:0]      tag_q, tag_d;
  logic [CW-1:0]          credit_q, credit_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   fold;

  // Ready depends only on the registered credit count.
  assign req_ready = (credit_q != '0);
  assign accept    = req_valid && req_ready;

  // Top bits 01/10 lie outside [-pi/2, pi/2); flipping the MSB subtracts pi.
  assign fold = req_angle[BITS-1] ^ req_angle[BITS-2];

  // Next-state for output register, tag line and credit counter.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    v_d      = 1'b0;
    flip_d   = flip_q;
    tag_d    = '0;
    credit_d = credit_q;
    err_d    = err_q;

    if (accept) begin
      x_d    = BITS'(XINIT);
      y_d    = '0;
      z_d    = fold ? {~req_angle[BITS-1], req_angle[BITS-2:0]} : req_angle;
      v_d    = 1'b1;
      flip_d = fold;
    end

    // Flip is pre-qualified by valid so the tap is a plain register bit.
    tag_d[0].v    = v_q;
    tag_d[0].flip = v_q & flip_q;
    for (int i = 1; i < int'(STAGES); i++) begin
      tag_d[i] = tag_q[i-1];
    end

    case ({accept, credit_ret})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CW'(CREDITS)) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      v_q      <= 1'b0;
      flip_q   <= 1'b0;
      tag_q    <= '0;
      credit_q <= CW'(CREDITS);
      err_q    <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      v_q      <= v_d;
      flip_q   <= flip_d;
      tag_q    <= tag_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign z_out      = z_q;
  assign v_out      = v_q;
  assign flip_tap   = tag_q[STAGES-1].flip;
  assign credit_err = err_q;

`ifdef CORDIC_FEEDER_STATS_EN
  logic [31:0] acc_cnt_q, stall_cnt_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end
      if (req_valid && !req_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stat_accepts = acc_cnt_q;
  assign stat_stalls  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cordic_feeder.sv
// Bench for cordic_feeder: directed fold table, credit corner sequences and
// randomized traffic against a behavioural model (credit integer, delay queue).
module tb_cordic_feeder;

  localparam int unsigned BITS    = 16;
  localparam int unsigned STAGES  = 16;
  localparam int unsigned CREDITS = 4;
  localparam int unsigned XINIT   = 9949;
  localparam int          QTR     = 2 ** (BITS - 2);
  localparam int          HALF    = 2 ** (BITS - 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [BITS-1:0] req_angle;
  logic            credit_ret;
  logic [BITS-1:0] x_out, y_out, z_out;
  logic            v_out, flip_tap, credit_err;
`ifdef CORDIC_FEEDER_STATS_EN
  logic [31:0]     stat_accepts, stat_stalls;
`endif

  always #5 clk = ~clk;

  cordic_feeder #(
    .BITS(BITS), .STAGES(STAGES), .CREDITS(CREDITS), .XINIT(XINIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_angle  (req_angle),
    .credit_ret (credit_ret),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .v_out      (v_out),
    .flip_tap   (flip_tap),
    .credit_err (credit_err)
`ifdef CORDIC_FEEDER_STATS_EN
    ,
    .stat_accepts (stat_accepts),
    .stat_stalls  (stat_stalls)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int              m_cred;
  bit              m_err;
  logic [BITS-1:0] m_x, m_y, m_z;
  bit              m_v;
  bit              m_flip;
  bit              tagq[$];
  int unsigned     m_acc_cnt, m_stall_cnt;
  int              n_seen;
  int              flips_seen;

  typedef struct {
    logic [BITS-1:0] angle;
    logic [BITS-1:0] exp_z;
    bit              exp_flip;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Angles beyond +/-pi/2 are rotated by pi (mod 2pi) and tagged for negation.
  function automatic void fold_ref(input logic [BITS-1:0] ang,
                                   output logic [BITS-1:0] z, output bit f);
    int a;
    a = int'($signed(ang));
    f = (a >= QTR) || (a < -QTR);
    z = f ? BITS'(a + HALF) : ang;
  endfunction

  // One clock: drive, advance model at the edge, then compare all outputs.
  task automatic cycle(input bit v, input logic [BITS-1:0] ang, input bit ret);
    bit              acc;
    bit              ff;
    logic [BITS-1:0] fz;
    req_valid  = v;
    req_angle  = ang;
    credit_ret = ret;
    @(posedge clk);
    if (reset) begin
      m_cred = CREDITS;
      m_err  = 0;
      m_x = '0; m_y = '0; m_z = '0;
      m_v = 0;
      m_flip = 0;
      tagq = {};
      repeat (STAGES) tagq.push_back(1'b0);
      m_acc_cnt = 0;
      m_stall_cnt = 0;
    end else begin
      acc = v && (m_cred != 0);
      if (v && m_cred == 0) m_stall_cnt++;
      fold_ref(ang, fz, ff);
      if (acc) begin
        m_x = BITS'(XINIT);
        m_y = '0;
        m_z = fz;
        m_acc_cnt++;
      end
      m_v = acc;
      tagq.push_back(acc && ff);
      m_flip = tagq.pop_front();
      if (acc && !ret) m_cred--;
      else if (ret && !acc) begin
        if (m_cred == int'(CREDITS)) m_err = 1;
        else m_cred++;
      end
    end
    #1;
    chk("req_ready", 32'(req_ready), 32'(m_cred != 0));
    chk("v_out", 32'(v_out), 32'(m_v));
    chk("x_out", 32'(x_out), 32'(m_x));
    chk("y_out", 32'(y_out), 32'(m_y));
    chk("z_out", 32'(z_out), 32'(m_z));
    chk("flip_tap", 32'(flip_tap), 32'(m_flip));
    chk("credit_err", 32'(credit_err), 32'(m_err));
`ifdef CORDIC_FEEDER_STATS_EN
    chk("stat_accepts", stat_accepts, m_acc_cnt);
    chk("stat_stalls", stat_stalls, m_stall_cnt);
`endif
    if (v_out === 1'b1) n_seen++;
    if (flip_tap === 1'b1) flips_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic return_credits(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    vecs[0] = '{16'h2000, 16'h2000, 1'b0};
    vecs[1] = '{16'h6000, 16'hE000, 1'b1};
    vecs[2] = '{16'h8000, 16'h0000, 1'b1};
    vecs[3] = '{16'h4000, 16'hC000, 1'b1};
    vecs[4] = '{16'hC000, 16'hC000, 1'b0};
    vecs[5] = '{16'hBFFF, 16'h3FFF, 1'b1};
    vecs[6] = '{16'h3FFF, 16'h3FFF, 1'b0};

    req_valid = 0; req_angle = '0; credit_ret = 0;

    // Reset for two cycles
    reset = 1;
    idle(2);
    reset = 0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_v", 32'(v_out), 32'd0);
    chk("rst_z", 32'(z_out), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);

    // Fold table: z next cycle, flip tag STAGES cycles later
    foreach (vecs[k]) begin
      cycle(1'b1, vecs[k].angle, 1'b0);
      chk("tbl_v", 32'(v_out), 32'd1);
      chk("tbl_x", 32'(x_out), 32'd9949);
      chk("tbl_y", 32'(y_out), 32'd0);
      chk("tbl_z", 32'(z_out), 32'(vecs[k].exp_z));
      idle(STAGES);
      chk("tbl_flip", 32'(flip_tap), 32'(vecs[k].exp_flip));
      cycle(1'b0, '0, 1'b1);
      chk("tbl_flip_gone", 32'(flip_tap), 32'd0);
    end

    // Credit exhaustion
    n_seen = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'(i * 1000), 1'b0);
    chk("exh_accepts", 32'(n_seen), 32'd4);
    chk("exh_ready", 32'(req_ready), 32'd0);
    cycle(1'b1, 16'h1234, 1'b1);
    chk("ret_at_zero_no_acc", 32'(v_out), 32'd0);
    chk("ret_at_zero_ready_next", 32'(req_ready), 32'd1);
    cycle(1'b1, 16'h1234, 1'b0);
    chk("one_more_acc", 32'(v_out), 32'd1);
    chk("ready_drop", 32'(req_ready), 32'd0);
    cycle(1'b1, 16'h1234, 1'b0);
    chk("no_acc_after", 32'(v_out), 32'd0);
    return_credits(4);

    // Simultaneous accept and return at count 2
    cycle(1'b1, 16'h0100, 1'b0);
    cycle(1'b1, 16'h0200, 1'b0);
    cycle(1'b1, 16'h0300, 1'b1);
    chk("sim_ready", 32'(req_ready), 32'd1);
    n_seen = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0400, 1'b0);
    chk("sim_count_two", 32'(n_seen), 32'd2);
    return_credits(4);

    // Overflow at full credits
    cycle(1'b0, '0, 1'b1);
    chk("ovf_err", 32'(credit_err), 32'd1);
    n_seen = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0500, 1'b0);
    chk("ovf_count_four", 32'(n_seen), 32'd4);
    return_credits(4);

    // Reset with three flipped tags in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h6000, 1'b0);
    idle(3);
    reset = 1;
    idle(1);
    reset = 0;
    chk("mid_rst_err", 32'(credit_err), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    flips_seen = 0;
    idle(STAGES + 2);
    chk("mid_rst_no_flip", 32'(flips_seen), 32'd0);
    n_seen = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0600, 1'b0);
    chk("mid_rst_credits", 32'(n_seen), 32'd4);
    return_credits(4);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 3) != 0, BITS'($urandom), $urandom_range(0, 2) == 0);
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_feeder.md
# cordic_feeder

Front-end of the rotation-mode CORDIC pipeline. It sits directly upstream of the first `cordic_stage` and accepts angle requests over a valid/ready handshake. Each angle is folded into the convergence range [-pi/2, pi/2), and the block drives the initial x/y/z/v vector into stage 0. The block also gates admission with a credit counter, because the stage pipeline cannot stall. A quadrant-flip tag travels through an internal delay line so it emerges aligned with the last stage's output.

## Interface
- `BITS`, 16: width of the angle and of the x/y/z datapath.
- `STAGES`, 16: number of `cordic_stage` instances downstream; sets the tag delay.
- `CREDITS`, 4: depth of the downstream result buffer; this is the maximum number of results in flight, with a minimum of 1.
- `XINIT`, 9949: initial x, equal to round(0.607253 * 2^(BITS-2)), which pre-compensates the CORDIC gain.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  an angle request is present.
- `req_ready`  out  1  the feeder accepts a request this cycle.
- `req_angle`  in  BITS  signed angle; +/-pi maps to +/-2^(BITS-1), with wrap-around arithmetic.
- `credit_ret`  in  1  pulse: downstream popped one result from its buffer.
- `x_out`  out  BITS  signed x, to stage 0 `x_in`.
- `y_out`  out  BITS  signed y, to stage 0 `y_in`.
- `z_out`  out  BITS  signed folded angle, to stage 0 `z_in`.
- `v_out`  out  1  valid, to stage 0 `v_in`.
- `flip_tap`  out  1  quadrant-flip flag, aligned with the last stage's `v_out`.
- `credit_err`  out  1  sticky flag: credit overflow.

## Operation
- **Accept condition:** a request is accepted when `req_valid && req_ready`.
  - `req_ready = (credit_cnt != 0)`.
  - `req_ready` is combinational from the registered `credit_cnt` only; it never depends on `req_valid`.
- **Folding**, using the top two bits of `req_angle`:
  - Top bits 00 or 11: pass through, flip = 0.
  - Top bits 01 or 10: `z = req_angle` with the MSB inverted (which subtracts pi modulo 2^BITS), flip = 1.
  - The downstream consumer negates both results when `flip_tap` = 1.
- **Output register:** on accept, the next cycle drives:
  - `x_out = XINIT`, `y_out = 0`, `z_out` = folded angle, `v_out = 1`.
  - If no request is accepted, `v_out = 0` and x/y/z hold their previous values.
- **Tag delay line:** a `STAGES`-deep shift register carrying {v, flip}.
  - It is fed from the output register every cycle.
  - `flip_tap` is the flip bit of the final element, qualified by that element's v bit: `flip_tap` = 0 whenever the element is not valid.
- **Credit counter:** width is `$clog2(CREDITS+1)`.
  - Accept alone: decrement.
  - `credit_ret` alone: increment.
  - Both in the same cycle: counter unchanged.
- **Boundary conditions:**
  - `credit_ret` while `credit_cnt == CREDITS` and no accept: counter saturates at `CREDITS` and `credit_err` sets. It clears only on reset.
  - `credit_cnt == 0` with `credit_ret` asserted: `req_ready` stays 0 that cycle. It rises the next cycle.
- **Throughput:** one request per cycle while credits remain.

## Timing
- **Reset values** (synchronous):
  - `x_out`/`y_out`/`z_out` = 0, `v_out` = 0.
  - Tag line cleared, `flip_tap` = 0.
  - `credit_cnt = CREDITS`, so `req_ready` = 1 the first cycle after reset deasserts.
  - `credit_err` = 0.
- **Reset mid-operation:** all in-flight tags are discarded and credits are restored to `CREDITS`. Downstream buffers must be reset in the same cycle.
- **Latency, accept to outputs:** accept in cycle t gives `v_out` = 1 in cycle t+1.
- **Latency, accept to tag:** `flip_tap` for that request is valid at cycle t+1+STAGES. This matches the last stage's `v_out`, since each stage adds one register.
- **`req_ready` drop:** after the accept that consumes the final credit, `req_ready` is 0 in the next cycle.

## Configuration
- **Macro:** `CORDIC_FEEDER_STATS_EN`.
- **Defined:** the block adds the following ports and counters.
  - `stat_accepts` (out, 32): increments on every accept.
  - `stat_stalls` (out, 32): increments on every cycle with `req_valid && !req_ready`.
  - Both wrap at 2^32 and reset to 0.
- **Undefined:** the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- **Reset:** hold `reset` 2 cycles, then release. Required: `req_ready` = 1, `v_out` = 0, `credit_err` = 0, all outputs 0.
- **No-fold request:** `req_angle = 0x2000` (pi/4). Required next cycle: `x_out` = 9949, `y_out` = 0, `z_out` = 0x2000, `v_out` = 1. At cycle t+17, `flip_tap` = 0 with the tag valid.
- **Folded requests:**
  - `req_angle = 0x6000` gives `z_out` = 0xE000 and `flip_tap` = 1 at t+17.
  - `req_angle = 0x8000` gives `z_out` = 0x0000 and flip = 1.
  - `req_angle = 0x4000` gives `z_out` = 0xC000 and flip = 1.
- **Credit exhaustion, `CREDITS` = 4:** hold `req_valid` with no `credit_ret`. Required: exactly 4 accepts in 4 cycles, then `req_ready` = 0. With STATS enabled, `stat_stalls` counts each blocked cycle. One `credit_ret` pulse gives `req_ready` = 1 on the next cycle and exactly one more accept.
- **Simultaneous accept and return:** at `credit_cnt` = 2, drive accept and `credit_ret` in the same cycle. Required: the count stays 2 and `req_ready` stays 1.
- **Overflow and reset mid-flight:**
  - `credit_ret` at `credit_cnt` = 4: required `credit_err` = 1 and the count stays 4.
  - Reset with 3 tags in flight: required all tags and `flip_tap` cleared, and `credit_cnt` = 4 after reset.
